// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction outstanding, round-robin on conflict.
// Latency: min 4 cycles per transaction (accept, REQ, RSP, DONE); RSP may be forced to an error after TIMEOUT cycles.
// Backpressure: mem_req_* held stable until mem_req_ready; response held on the owner's rsp bus until its rsp_ready.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [DATA_W-1:0]     ifu_rsp_rdata,
    output logic                  ifu_rsp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wstrb,
    output logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_ready,
    output logic [DATA_W-1:0]     lsu_rsp_rdata,
    output logic                  lsu_rsp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wstrb,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_W-1:0]     mem_rsp_rdata,
    input  logic                  mem_rsp_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                last_grant;   // 0 = IFU, 1 = LSU
    logic                grant_id;
    logic                grant_lsu;
    logic                accept;
    logic                cnt_hit;
    logic                owner_rsp_ready;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    // On a conflict the master that did not win last time gets the port.
    always_comb begin
        grant_lsu       = lsu_req_valid && (!ifu_req_valid || !last_grant);
        accept          = (state == IDLE) && (ifu_req_valid || lsu_req_valid);
        cnt_hit         = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
        owner_rsp_ready = grant_id ? lsu_rsp_ready : ifu_rsp_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ:  if (mem_req_ready) state_nxt = RSP;
            RSP:  if (mem_rsp_valid || cnt_hit) state_nxt = DONE;
            DONE: if (owner_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready = (state == IDLE) && ifu_req_valid && !grant_lsu;
        lsu_req_ready = (state == IDLE) && grant_lsu;
        mem_req_valid = (state == REQ);
        mem_rsp_ready = (state == IDLE) || (state == RSP);
        ifu_rsp_valid = (state == DONE) && !grant_id;
        lsu_rsp_valid = (state == DONE) && grant_id;
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;
    assign ifu_rsp_rdata = rdata_q;
    assign ifu_rsp_err   = err_q;
    assign lsu_rsp_rdata = rdata_q;
    assign lsu_rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b0;
            grant_id   <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                grant_id   <= grant_lsu;
                last_grant <= grant_lsu;
                addr_q     <= grant_lsu ? lsu_req_addr : ifu_req_addr;
                wen_q      <= grant_lsu && lsu_req_wen;
                wdata_q    <= grant_lsu ? lsu_req_wdata : '0;
                wstrb_q    <= grant_lsu ? lsu_req_wstrb : '0;
            end
            if (state == REQ) begin
                cnt <= '0;
            end else if (state == RSP) begin
                cnt <= cnt + 1'b1;
            end
            // A real response in the timeout cycle takes priority over the forced error.
            if (state == RSP) begin
                if (mem_rsp_valid) begin
                    rdata_q <= mem_rsp_rdata;
                    err_q   <= mem_rsp_err;
                end else if (cnt_hit) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

endmodule
